// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
//
// Multi-cycle sequencer for the MUL / IMUL / DIV / IDIV family. Operands are
// latched on an accepted start, then a 32-iteration radix-2 loop runs:
// shift-add for multiplies, restoring shift-subtract for divides. The 64-bit
// EDX:EAX result, the multiply CF/OF value and the #DE fault are returned
// with a one-cycle done pulse.
//
// Optional feature macro: MULDIV_SIGNED_EN
//   defined   - IMUL/IDIV are handled with sign-magnitude pre/post processing
//   undefined - no sign logic; IMUL/IDIV are rejected with a fault in PREP
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   request, sampled only in IDLE
//   op[1:0]    in   0=MUL 1=IMUL 2=DIV 3=IDIV
//   opnd_hi    in   EDX, dividend high (ignored for multiplies)
//   opnd_lo    in   EAX, multiplicand / dividend low
//   opnd_src   in   r/m operand, multiplier / divisor
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse in DONE
//   result_lo  out  product low / quotient
//   result_hi  out  product high / remainder
//   ovf        out  multiply CF=OF, 0 for divides
//   fault      out  #DE, valid with done, 0 for multiplies
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands captured on accept
// PREP  | operand magnitudes, sign capture, divide range/zero check
// RUN   | one shift-add / shift-subtract iteration per cycle, 32 total
// FIX   | sign correction, IDIV overflow check, ovf evaluation
// DONE  | done pulse, registered results presented
// ---------------------------------------------------------------------------
module muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opnd_hi,
    input  logic [31:0] opnd_lo,
    input  logic [31:0] opnd_src,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi,
    output logic        ovf,
    output logic        fault
);

    localparam logic [4:0] ST_IDLE = 5'b00001;
    localparam logic [4:0] ST_PREP = 5'b00010;
    localparam logic [4:0] ST_RUN  = 5'b00100;
    localparam logic [4:0] ST_FIX  = 5'b01000;
    localparam logic [4:0] ST_DONE = 5'b10000;

    localparam int S_IDLE = 0;
    localparam int S_PREP = 1;
    localparam int S_RUN  = 2;
    localparam int S_FIX  = 3;
    localparam int S_DONE = 4;

    localparam logic [5:0] LAST_ITER = 6'd31;

    logic [4:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [5:0]  cnt_q, cnt_d;
    // hi_q:lo_q is the working pair: EDX:EAX while latched, then the
    // accumulator:multiplier (multiply) or remainder:quotient (divide).
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] src_q, src_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic        ovf_q, ovf_d;
    logic        fault_q, fault_d;
`ifdef MULDIV_SIGNED_EN
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic        prep_neg_dvd;
    logic        prep_neg_src;
    logic [63:0] prod_neg;
    logic        quot_big;
`endif

    logic        is_div;
    logic        is_signed;
    logic [31:0] src_mag;
    logic [63:0] dvd_mag;
    logic        prep_fault;
    logic [32:0] mul_sum;
    logic [32:0] div_rem;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [31:0] fix_lo;
    logic [31:0] fix_hi;
    logic        fix_ovf;
    logic        fix_fault;

    assign is_div    = op_q[1];
    assign is_signed = op_q[0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = ST_IDLE;
        if (state_q[S_IDLE]) begin
            state_d = start ? ST_PREP : ST_IDLE;
        end else if (state_q[S_PREP]) begin
            state_d = prep_fault ? ST_DONE : ST_RUN;
        end else if (state_q[S_RUN]) begin
            state_d = (cnt_q == LAST_ITER) ? ST_FIX : ST_RUN;
        end else if (state_q[S_FIX]) begin
            state_d = ST_DONE;
        end else begin
            // DONE, or any non-one-hot code, returns to IDLE
            state_d = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (registered state and result registers only)
    // ------------------------------------------------------------------
    always_comb begin
        busy      = ~state_q[S_IDLE];
        done      = state_q[S_DONE];
        result_lo = res_lo_q;
        result_hi = res_hi_q;
        ovf       = ovf_q;
        fault     = fault_q;
    end

    // ------------------------------------------------------------------
    // PREP: magnitudes and divide range check
    // ------------------------------------------------------------------
`ifdef MULDIV_SIGNED_EN
    always_comb begin
        prep_neg_src = is_signed & src_q[31];
        prep_neg_dvd = is_signed & (is_div ? hi_q[31] : lo_q[31]);
        src_mag      = prep_neg_src ? (32'd0 - src_q) : src_q;
        if (is_div) begin
            dvd_mag = prep_neg_dvd ? (64'd0 - {hi_q, lo_q}) : {hi_q, lo_q};
        end else begin
            // multiplicand is 32-bit; the accumulator half starts cleared
            dvd_mag = {32'd0, (prep_neg_dvd ? (32'd0 - lo_q) : lo_q)};
        end
        // the quotient fits in 32 bits only if the high half of the
        // dividend is strictly below the divisor
        prep_fault = is_div & ((src_mag == 32'd0) | (dvd_mag[63:32] >= src_mag));
    end
`else
    always_comb begin
        src_mag    = src_q;
        dvd_mag    = is_div ? {hi_q, lo_q} : {32'd0, lo_q};
        // without sign support IMUL/IDIV are rejected outright
        prep_fault = is_signed
                   | (is_div & ((src_mag == 32'd0) | (dvd_mag[63:32] >= src_mag)));
    end
`endif

    // ------------------------------------------------------------------
    // RUN: one iteration
    // ------------------------------------------------------------------
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, src_q} : 33'd0);
        // remainder after the left shift is 33 bits wide
        div_rem  = {hi_q, lo_q[31]};
        div_ge   = (div_rem >= {1'b0, src_q});
        // when div_ge, the true difference is below the divisor, so the
        // low 32 bits of the subtraction are exact
        div_diff = div_rem[31:0] - src_q;
    end

    // ------------------------------------------------------------------
    // FIX: sign correction, IDIV overflow, ovf
    // ------------------------------------------------------------------
    always_comb begin
        fix_lo    = lo_q;
        fix_hi    = hi_q;
        fix_fault = 1'b0;
`ifdef MULDIV_SIGNED_EN
        prod_neg  = 64'd0 - {hi_q, lo_q};
        quot_big  = neg_quot_q ? (lo_q > 32'h8000_0000) : (lo_q > 32'h7FFF_FFFF);
        if (is_signed && !is_div) begin
            if (neg_quot_q) begin
                fix_hi = prod_neg[63:32];
                fix_lo = prod_neg[31:0];
            end
        end else if (is_signed && is_div) begin
            if (quot_big) begin
                fix_fault = 1'b1;
                fix_lo    = 32'd0;
                fix_hi    = 32'd0;
            end else begin
                fix_lo = neg_quot_q ? (32'd0 - lo_q) : lo_q;
                fix_hi = neg_rem_q  ? (32'd0 - hi_q) : hi_q;
            end
        end
`endif
        if (is_div) begin
            fix_ovf = 1'b0;
        end else if (is_signed) begin
            fix_ovf = (fix_hi != {32{fix_lo[31]}});
        end else begin
            fix_ovf = (fix_hi != 32'd0);
        end
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        op_d     = op_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        src_d    = src_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        ovf_d    = ovf_q;
        fault_d  = fault_q;
`ifdef MULDIV_SIGNED_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif
        if (state_q[S_IDLE]) begin
            if (start) begin
                op_d  = op;
                hi_d  = opnd_hi;
                lo_d  = opnd_lo;
                src_d = opnd_src;
            end
        end
        if (state_q[S_PREP]) begin
            hi_d  = dvd_mag[63:32];
            lo_d  = dvd_mag[31:0];
            src_d = src_mag;
            cnt_d = 6'd0;
`ifdef MULDIV_SIGNED_EN
            neg_quot_d = prep_neg_dvd ^ prep_neg_src;
            neg_rem_d  = prep_neg_dvd;
`endif
            // previous results stay visible unless this op faults here
            if (prep_fault) begin
                res_lo_d = 32'd0;
                res_hi_d = 32'd0;
                ovf_d    = 1'b0;
                fault_d  = 1'b1;
            end
        end
        if (state_q[S_RUN]) begin
            if (cnt_q != LAST_ITER) begin
                cnt_d = cnt_q + 6'd1;
            end
            if (is_div) begin
                hi_d = div_ge ? div_diff : div_rem[31:0];
                lo_d = {lo_q[30:0], div_ge};
            end else begin
                hi_d = mul_sum[32:1];
                lo_d = {mul_sum[0], lo_q[31:1]};
            end
        end
        if (state_q[S_FIX]) begin
            cnt_d    = 6'd0;
            res_lo_d = fix_lo;
            res_hi_d = fix_hi;
            ovf_d    = fix_ovf;
            fault_d  = fix_fault;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= 2'd0;
            cnt_q    <= 6'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            src_q    <= 32'd0;
            res_lo_q <= 32'd0;
            res_hi_q <= 32'd0;
            ovf_q    <= 1'b0;
            fault_q  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            src_q    <= src_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            ovf_q    <= ovf_d;
            fault_q  <= fault_d;
`ifdef MULDIV_SIGNED_EN
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq
//
// Directed vectors for muldiv_seq. The driver pushes the hand-computed
// expected response into a queue when it launches an operation; a monitor
// on the falling edge pops and compares whenever done is high, including
// the done latency measured from the start cycle.
// ---------------------------------------------------------------------------
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opnd_hi;
    logic [31:0] opnd_lo;
    logic [31:0] opnd_src;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        ovf;
    logic        fault;

    muldiv_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .opnd_hi   (opnd_hi),
        .opnd_lo   (opnd_lo),
        .opnd_src  (opnd_src),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .ovf       (ovf),
        .fault     (fault)
    );

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_IMUL = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;
    localparam logic [1:0] OP_IDIV = 2'd3;

    typedef struct {
        string       nm;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        ovf;
        logic        fault;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;
    int   cyc;
    int   done_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done at cycle %0d lo=0x%0h hi=0x%0h fault=%0b",
                         cyc, result_lo, result_hi, fault);
            end else begin
                e = sb.pop_front();
                chk({e.nm, "_lo"},    64'(result_lo), 64'(e.lo));
                chk({e.nm, "_hi"},    64'(result_hi), 64'(e.hi));
                chk({e.nm, "_ovf"},   64'(ovf),       64'(e.ovf));
                chk({e.nm, "_fault"}, 64'(fault),     64'(e.fault));
                chk({e.nm, "_lat"},   64'(cyc - e.t0), 64'(e.lat));
                chk({e.nm, "_busy"},  64'(busy),      64'd1);
            end
        end
    end

    // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 of the
    // cycle following done (the earliest cycle a new start is accepted).
    task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] h,
                         input logic [31:0] l, input logic [31:0] s,
                         input logic [31:0] elo, input logic [31:0] ehi,
                         input logic eovf, input logic efault, input int lat);
        exp_t e;
        bit   seen;
        op       = o;
        opnd_hi  = h;
        opnd_lo  = l;
        opnd_src = s;
        start    = 1'b1;
        e.nm = nm; e.lo = elo; e.hi = ehi; e.ovf = eovf; e.fault = efault;
        e.lat = lat; e.t0 = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no done within 60 cycles", nm);
        end
        @(posedge clk); #1;
        chk({nm, "_idle_after"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin : driver
        int d0;
        bit busy_ok;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = OP_MUL;
        opnd_hi  = 32'd0;
        opnd_lo  = 32'd0;
        opnd_src = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({busy, done, ovf, fault}), 64'd0);
        chk("reset_results", {result_hi, result_lo}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MUL FFFFFFFF*FFFFFFFF with start pulses in cycles 5 and 35
        begin
            exp_t e;
            op = OP_MUL; opnd_hi = 32'hDEAD_BEEF;
            opnd_lo = 32'hFFFF_FFFF; opnd_src = 32'hFFFF_FFFF;
            start = 1'b1;
            e.nm = "mul_max"; e.lo = 32'h0000_0001; e.hi = 32'hFFFF_FFFE;
            e.ovf = 1'b1; e.fault = 1'b0; e.lat = 35; e.t0 = cyc;
            sb.push_back(e);
            d0 = done_cnt;
            busy_ok = 1'b1;
            for (int k = 1; k <= 45; k++) begin
                @(posedge clk); #1;
                start = 1'b0;
                if (k == 5 || k == 35) begin
                    // a divide-by-zero would fault quickly if wrongly accepted
                    start = 1'b1; op = OP_DIV; opnd_hi = 32'd0; opnd_src = 32'd0;
                end
                if (k >= 1 && k <= 35) busy_ok = busy_ok & busy;
                if (k == 36) chk("mul_max_busy_fall", 64'(busy), 64'd0);
            end
            chk("mul_max_busy_1_35", 64'(busy_ok), 64'd1);
            chk("ignored_start_one_done", 64'(done_cnt - d0), 64'd1);
        end

        // synchronous reset mid-RUN
        op = OP_MUL; opnd_hi = 32'd0; opnd_lo = 32'd3; opnd_src = 32'd5;
        start = 1'b1;
        d0 = done_cnt;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("run_busy_before_reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrun_reset_flags", 64'({busy, done, ovf, fault}), 64'd0);
        chk("midrun_reset_results", {result_hi, result_lo}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("no_done_after_reset", 64'(done_cnt - d0), 64'd0);

        issue("mul_7x6",    OP_MUL, 32'h1234_5678, 32'd7, 32'd6,
              32'd42, 32'd0, 1'b0, 1'b0, 35);
        issue("mul_2p32",   OP_MUL, 32'd0, 32'h0001_0000, 32'h0001_0000,
              32'd0, 32'd1, 1'b1, 1'b0, 35);
        issue("mul_zero",   OP_MUL, 32'd0, 32'h0000_1234, 32'd0,
              32'd0, 32'd0, 1'b0, 1'b0, 35);
        issue("div_2p32",   OP_DIV, 32'd1, 32'd0, 32'h10,
              32'h1000_0000, 32'd0, 1'b0, 1'b0, 35);
        issue("div_100_7",  OP_DIV, 32'd0, 32'd100, 32'd7,
              32'd14, 32'd2, 1'b0, 1'b0, 35);
        issue("div_maxq",   OP_DIV, 32'hF, 32'hFFFF_FFFF, 32'h10,
              32'hFFFF_FFFF, 32'hF, 1'b0, 1'b0, 35);
        issue("div_by0",    OP_DIV, 32'h5, 32'h6, 32'd0,
              32'd0, 32'd0, 1'b0, 1'b1, 2);
        issue("div_range",  OP_DIV, 32'h20, 32'd0, 32'h10,
              32'd0, 32'd0, 1'b0, 1'b1, 2);
        issue("div_equal",  OP_DIV, 32'h10, 32'h0, 32'h10,
              32'd0, 32'd0, 1'b0, 1'b1, 2);
        issue("div_after_fault", OP_DIV, 32'd0, 32'd9, 32'd3,
              32'd3, 32'd0, 1'b0, 1'b0, 35);
`ifdef MULDIV_SIGNED_EN
        issue("idiv_m7_2",  OP_IDIV, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 35);
        issue("idiv_7_m2",  OP_IDIV, 32'd0, 32'd7, 32'hFFFF_FFFE,
              32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 35);
        issue("imul_m3_5",  OP_IMUL, 32'hCAFE_F00D, 32'hFFFF_FFFD, 32'd5,
              32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 1'b0, 35);
        issue("imul_m1_m1", OP_IMUL, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'd1, 32'd0, 1'b0, 1'b0, 35);
        issue("imul_2p32",  OP_IMUL, 32'd0, 32'h0001_0000, 32'h0001_0000,
              32'd0, 32'd1, 1'b1, 1'b0, 35);
        issue("idiv_qovf",  OP_IDIV, 32'd0, 32'h8000_0000, 32'd1,
              32'd0, 32'd0, 1'b0, 1'b1, 35);
        issue("idiv_minq",  OP_IDIV, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,
              32'h8000_0000, 32'd0, 1'b0, 1'b0, 35);
`else
        issue("imul_nosign", OP_IMUL, 32'd0, 32'd3, 32'd5,
              32'd0, 32'd0, 1'b0, 1'b1, 2);
        issue("idiv_nosign", OP_IDIV, 32'd0, 32'd7, 32'd2,
              32'd0, 32'd0, 1'b0, 1'b1, 2);
`endif
        issue("mul_final",  OP_MUL, 32'd0, 32'h8000_0000, 32'd2,
              32'd0, 32'd1, 1'b1, 1'b0, 35);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the x86 MUL/IMUL/DIV/IDIV family. `execute` decodes one of these commands, latches operands, and hands the operation to this block. The block then runs a radix-2 shift-add (multiply) or restoring shift-subtract (divide) loop over 32 iterations. It returns the 64-bit EDX:EAX result, the MUL CF/OF condition and the #DE fault. All other ALU commands stay single-cycle and never use this block.

## Interface
- No parameters; operand width fixed at 32 bits.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `op` in 2: 0=MUL, 1=IMUL, 2=DIV, 3=IDIV.
- `opnd_hi` in 32: EDX (dividend high); ignored for MUL/IMUL.
- `opnd_lo` in 32: EAX (multiplicand / dividend low).
- `opnd_src` in 32: r/m operand (multiplier / divisor).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in DONE.
- `result_lo` out 32: product low / quotient (EAX).
- `result_hi` out 32: product high / remainder (EDX).
- `ovf` out 1: MUL/IMUL CF=OF value; 0 for divides.
- `fault` out 1: #DE, valid with `done`; 0 for multiplies.

## Operation
- States: IDLE, PREP, RUN, FIX, DONE; encoded one-hot.
- IDLE
  - With `start`=1: capture `op` and all operands, go to PREP.
  - With `start`=0: stay in IDLE.
- PREP
  - Signed ops: take the magnitude of each operand; record sign_q = sign(dividend or multiplicand) XOR sign(src) and sign_r = sign(dividend).
  - Clear the 6-bit iteration counter.
  - DIV/IDIV: if divisor magnitude = 0, or dividend-high magnitude >= divisor magnitude, set `fault`, force results to 0 and go to DONE.
  - Otherwise go to RUN.
- RUN, one iteration per cycle, 32 iterations; counter 0..31, exit to FIX when counter = 31.
  - Multiply: if acc_lo[0], add src to the upper 33 bits, then shift right by 1.
  - Divide: shift the 64-bit remainder:quotient pair left; if rem[63:32] >= divisor, subtract the divisor and set the quotient LSB. The compare is 33-bit unsigned.
- FIX
  - IMUL: negate the 64-bit product if sign_q.
  - IDIV: negate the quotient if sign_q; negate the remainder if sign_r.
  - IDIV overflow, sets `fault` and zeroes results:
    - magnitude quotient > 0x7FFFFFFF with sign_q = 0, or
    - magnitude quotient > 0x80000000 with sign_q = 1.
  - `ovf`:
    - MUL: result_hi != 0.
    - IMUL: result_hi != {32{result_lo[31]}}.
  - Go to DONE.
- DONE
  - Assert `done`; `result_*`, `ovf` and `fault` are registered.
  - Go to IDLE. Results hold until the next PREP.
- `start` while `busy` is ignored and is not queued.
- `start` in the DONE cycle is also ignored; the caller must wait for IDLE.

## Timing
- Reset, taken on any edge with `rst_n`=0, including mid-RUN: state IDLE, counter 0, and `busy`, `done`, `ovf`, `fault`, `result_lo`, `result_hi` all 0.
- Nominal latency, with `start` high in cycle 0 (IDLE):
  - PREP in cycle 1.
  - RUN in cycles 2–33.
  - FIX in cycle 34.
  - `done` high in cycle 35.
  - Back in IDLE at cycle 36, earliest next accept.
- Fault latency for divide-by-zero or unsigned-range overflow: `done` and `fault` high in cycle 2.
- `busy` rises in cycle 1 and falls in cycle 36.
- Latency is data-independent apart from the PREP fault short-cut; there is no early termination.
- No combinational path from inputs to outputs.

## Configuration
- `MULDIV_SIGNED_EN`
  - Defined: IMUL/IDIV supported as above, including the sign-magnitude PREP/FIX logic.
  - Undefined: sign logic is not built.
    - `op`=1 or 3 takes the PREP fault short-cut: `done` and `fault` in cycle 2, results 0, `ovf` 0.
    - MUL and DIV are unchanged.

## Test plan
- MUL: `opnd_lo`=0xFFFFFFFF, `opnd_src`=0xFFFFFFFF.
  - Cycle 35: `done`=1, `result_hi`=0xFFFFFFFE, `result_lo`=0x00000001, `ovf`=1, `fault`=0.
  - `busy` high over cycles 1–35.
- DIV: EDX:EAX=0x00000001_00000000, `opnd_src`=0x10.
  - Expect `result_lo`=0x10000000, `result_hi`=0, `fault`=0 at cycle 35.
- DIV by 0 (any dividend), and separately DIV with EDX=0x20, `opnd_src`=0x10.
  - Both: `done`=`fault`=1 in cycle 2, results 0.
- With `MULDIV_SIGNED_EN`:
  - IDIV 0xFFFFFFFF_FFFFFFF9 / 2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - IMUL 0xFFFFFFFD × 5: `result_hi`=0xFFFFFFFF, `result_lo`=0xFFFFFFF1, `ovf`=0.
  - IDIV 0x00000000_80000000 / 1: `fault`=1 at cycle 35.
- Without `MULDIV_SIGNED_EN`: IMUL 3 × 5 → `fault`=1 in cycle 2, results 0.
- Control:
  - `start` pulsed in cycles 5 and 35 of a running op is ignored, and exactly one `done` occurs.
  - `rst_n`=0 in cycle 10 of RUN: all outputs 0 and IDLE next cycle.
  - A fresh MUL 7 × 6 afterwards returns 42 at its cycle 35.
